// File: rtl/ppu_quant_if.sv
// Accumulator-row stream from the matmul controller into the PPU and the
// requantized row stream out of it.
interface ppu_quant_if;
  logic         i_ppu_start;
  logic [383:0] i_acc_data;
  logic [1:0]   i_mode;
  logic         i_findmax;
  logic         o_valid;
  logic [127:0] o_data;
  logic [4:0]   o_scale;
  logic [3:0]   o_row;
  logic         o_busy;

  modport master (
    output i_ppu_start, i_acc_data, i_mode, i_findmax,
    input  o_valid, o_data, o_scale, o_row, o_busy
  );

  modport slave (
    input  i_ppu_start, i_acc_data, i_mode, i_findmax,
    output o_valid, o_data, o_scale, o_row, o_busy
  );
endinterface

// File: rtl/ppu_quant.sv
// Post-processing unit: requantizes 16x INT24 accumulator rows to INT8/INT4
// using a per-tensor shift (from a findmax pass) or a per-row shift (VSQ).
module ppu_quant (
  input  logic       i_clk,
  input  logic       i_rst_n,
  ppu_quant_if.slave ppu
);
  localparam logic [1:0] MODE_INT8     = 2'd0;
  localparam logic [1:0] MODE_INT4     = 2'd1;
  localparam logic [1:0] MODE_INT4_VSQ = 2'd2;
  localparam int DATA_W = 24;
  localparam int OUT_W  = 8;
  localparam int MAG_W  = 23;
  localparam int LANES  = 16;

  typedef enum logic {S_IDLE, S_RECV} state_t;

  state_t             state_q, state_d;
  logic [3:0]         row_cnt_q;
  logic [1:0]         mode_q;
  logic               findmax_q;
  logic [MAG_W-1:0]   max_abs_r;
  logic               start_acc;
  logic               start_fm;
  logic               q4_p0;
  logic               calc_row_p0;
  logic [MAG_W-1:0]   mag_p0 [LANES];
  logic [MAG_W-1:0]   row_max_p0;
  logic [4:0]         shift_p0;
  logic [127:0]       quant_p0;
  logic               vld_p1;
  logic [127:0]       data_p1;
  logic [4:0]         scale_p1;
  logic [3:0]         row_p1;

  // |x| with -2^23 pinned to the largest representable magnitude
  function automatic logic [MAG_W-1:0] abs_sat(input logic signed [DATA_W-1:0] x);
    if (x == {1'b1, {(DATA_W-1){1'b0}}}) return {MAG_W{1'b1}};
    if (x < 0) return MAG_W'(-x);
    return x[MAG_W-1:0];
  endfunction

  function automatic logic [4:0] bit_len(input logic [MAG_W-1:0] m);
    logic [4:0] len;
    len = 5'd0;
    for (int i = 0; i < MAG_W; i++)
      if (m[i]) len = 5'(i + 1);
    return len;
  endfunction

  function automatic logic [4:0] calc_shift(input logic [MAG_W-1:0] m, input logic q4);
    logic [4:0] len;
    logic [4:0] thr;
    len = bit_len(m);
    thr = q4 ? 5'd3 : 5'd7;
    return (len > thr) ? (len - thr) : 5'd0;
  endfunction

  // Round half up then arithmetic shift; 25 bits hold x + 2^19 without wrap
  function automatic logic signed [DATA_W:0] round_shift(input logic signed [DATA_W-1:0] x,
                                                         input logic [4:0] s);
    logic [DATA_W:0]        rnd;
    logic signed [DATA_W:0] sum;
    rnd = (s != 5'd0) ? ({{DATA_W{1'b0}}, 1'b1} << (s - 5'd1)) : '0;
    sum = $signed({x[DATA_W-1], x}) + $signed(rnd);
    return sum >>> s;
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [DATA_W:0] y,
                                                       input logic q4);
    logic signed [DATA_W:0] hi;
    logic signed [DATA_W:0] lo;
    hi = q4 ? 25'sd7 : 25'sd127;
    lo = q4 ? -25'sd8 : -25'sd128;
    if (y > hi) return hi[OUT_W-1:0];
    if (y < lo) return lo[OUT_W-1:0];
    return y[OUT_W-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ppu.i_ppu_start) state_d = S_RECV;
      S_RECV:  if (row_cnt_q == 4'd15) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign start_acc   = (state_q == S_IDLE) && ppu.i_ppu_start;
  assign start_fm    = ppu.i_findmax && (ppu.i_mode != MODE_INT4_VSQ);
  assign q4_p0       = (mode_q == MODE_INT4) || (mode_q == MODE_INT4_VSQ);
  assign calc_row_p0 = (state_q == S_RECV) && !findmax_q;

  // p0: incoming row, magnitudes, shift selection and quantization
  always_comb begin
    row_max_p0 = '0;
    for (int k = 0; k < LANES; k++) begin
      mag_p0[k] = abs_sat($signed(ppu.i_acc_data[k*DATA_W +: DATA_W]));
      if (mag_p0[k] > row_max_p0) row_max_p0 = mag_p0[k];
    end
  end

  assign shift_p0 = calc_shift((mode_q == MODE_INT4_VSQ) ? row_max_p0 : max_abs_r, q4_p0);

  always_comb begin
    quant_p0 = '0;
    for (int k = 0; k < LANES; k++)
      quant_p0[k*OUT_W +: OUT_W] =
        saturate(round_shift($signed(ppu.i_acc_data[k*DATA_W +: DATA_W]), shift_p0), q4_p0);
  end

  // p1: registered output row
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      row_cnt_q <= 4'd0;
      mode_q    <= MODE_INT8;
      findmax_q <= 1'b0;
      max_abs_r <= '0;
      vld_p1    <= 1'b0;
      data_p1   <= '0;
      scale_p1  <= 5'd0;
      row_p1    <= 4'd0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        mode_q    <= ppu.i_mode;
        findmax_q <= start_fm;
        row_cnt_q <= 4'd0;
        // A findmax after a calc tile starts a new matrix
        if (start_fm && !findmax_q) max_abs_r <= '0;
      end else if (state_q == S_RECV) begin
        row_cnt_q <= row_cnt_q + 4'd1;
        if (findmax_q && (row_max_p0 > max_abs_r)) max_abs_r <= row_max_p0;
      end
      vld_p1 <= calc_row_p0;
      if (calc_row_p0) begin
        data_p1  <= quant_p0;
        scale_p1 <= shift_p0;
        row_p1   <= row_cnt_q;
      end
    end
  end

  assign ppu.o_valid = vld_p1;
  assign ppu.o_data  = data_p1;
  assign ppu.o_scale = scale_p1;
  assign ppu.o_row   = row_p1;
  assign ppu.o_busy  = (state_q == S_RECV);
endmodule

// File: tb/tb_ppu_quant.sv
// Directed bench for ppu_quant: per-tensor INT8/INT4, per-row VSQ, extreme
// input, ignored/back-to-back starts and mid-tile reset.
module tb_ppu_quant;
  localparam logic [1:0] INT8     = 2'd0;
  localparam logic [1:0] INT4     = 2'd1;
  localparam logic [1:0] INT4_VSQ = 2'd2;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [383:0] tile      [16];
  logic [127:0] exp_data  [16];
  logic [4:0]   exp_scale [16];

  ppu_quant_if bus ();

  ppu_quant dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .ppu     (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_tile();
    for (int r = 0; r < 16; r++) begin
      tile[r]      = '0;
      exp_data[r]  = '0;
      exp_scale[r] = 5'd0;
    end
  endtask

  task automatic set_in(input int r, input int k, input int val);
    tile[r][k*24 +: 24] = 24'(val);
  endtask

  task automatic set_exp(input int r, input int k, input int val);
    exp_data[r][k*8 +: 8] = 8'(val);
  endtask

  task automatic set_scale_all(input logic [4:0] s);
    for (int r = 0; r < 16; r++) exp_scale[r] = s;
  endtask

  task automatic start_tile(input logic [1:0] mode, input logic fm);
    bus.i_ppu_start = 1'b1;
    bus.i_mode      = mode;
    bus.i_findmax   = fm;
    bus.i_acc_data  = '0;
    check_eq("busy_at_start", {127'd0, bus.o_busy}, 128'd0);
    tick();
    bus.i_ppu_start = 1'b0;
  endtask

  // Drives the 16 rows of `tile`; each row's result is checked one cycle later.
  task automatic recv_rows(input logic exp_vld, input int glitch_row, input int rst_row);
    for (int r = 0; r < 16; r++) begin
      bus.i_acc_data = tile[r];
      if (r == glitch_row) begin
        bus.i_ppu_start = 1'b1;
        bus.i_findmax   = 1'b1;
        bus.i_mode      = INT4;
      end
      if (r == rst_row) i_rst_n = 1'b0;
      check_eq($sformatf("busy_r%0d", r), {127'd0, bus.o_busy}, 128'd1);
      tick();
      bus.i_ppu_start = 1'b0;
      if (r == rst_row) begin
        check_eq("rst_valid", {127'd0, bus.o_valid}, 128'd0);
        check_eq("rst_busy",  {127'd0, bus.o_busy},  128'd0);
        check_eq("rst_data",  bus.o_data, 128'd0);
        check_eq("rst_scale", {123'd0, bus.o_scale}, 128'd0);
        check_eq("rst_row",   {124'd0, bus.o_row},   128'd0);
        i_rst_n = 1'b1;
        bus.i_acc_data = '0;
        return;
      end
      check_eq($sformatf("valid_r%0d", r), {127'd0, bus.o_valid}, {127'd0, exp_vld});
      if (exp_vld) begin
        check_eq($sformatf("row_r%0d", r),   {124'd0, bus.o_row},   128'(r));
        check_eq($sformatf("scale_r%0d", r), {123'd0, bus.o_scale}, {123'd0, exp_scale[r]});
        check_eq($sformatf("data_r%0d", r),  bus.o_data, exp_data[r]);
      end
    end
  endtask

  task automatic idle_check(input string tag);
    bus.i_acc_data = '0;
    tick();
    check_eq({tag, "_valid"}, {127'd0, bus.o_valid}, 128'd0);
    check_eq({tag, "_busy"},  {127'd0, bus.o_busy},  128'd0);
  endtask

  initial begin
    bus.i_ppu_start = 1'b0;
    bus.i_acc_data  = '0;
    bus.i_mode      = INT8;
    bus.i_findmax   = 1'b0;

    // Reset held for two cycles
    tick();
    tick();
    check_eq("reset_valid", {127'd0, bus.o_valid}, 128'd0);
    check_eq("reset_busy",  {127'd0, bus.o_busy},  128'd0);
    check_eq("reset_data",  bus.o_data, 128'd0);
    check_eq("reset_scale", {123'd0, bus.o_scale}, 128'd0);
    check_eq("reset_row",   {124'd0, bus.o_row},   128'd0);
    i_rst_n = 1'b1;
    tick();

    // INT8 findmax: max 300 lands on the last row
    clear_tile();
    set_in(15, 7, -300);
    start_tile(INT8, 1'b1);
    recv_rows(1'b0, -1, -1);

    // INT8 calc started at T+17, with a start pulse at T+5 that must be ignored
    clear_tile();
    set_in(0, 0, 300);  set_exp(0, 0, 75);
    set_in(0, 1, -300); set_exp(0, 1, -75);
    set_in(9, 15, 300); set_exp(9, 15, 75);
    set_in(12, 3, 5);   set_exp(12, 3, 1);
    set_scale_all(5'd2);
    start_tile(INT8, 1'b0);
    recv_rows(1'b1, 4, -1);

    // INT4 findmax max 15, then calc: 15 -> 7 (saturated), -15 -> -7
    clear_tile();
    set_in(2, 3, -15);
    start_tile(INT4, 1'b1);
    recv_rows(1'b0, -1, -1);
    clear_tile();
    set_in(0, 0, 15);  set_exp(0, 0, 7);
    set_in(0, 1, -15); set_exp(0, 1, -7);
    set_in(5, 2, 3);   set_exp(5, 2, 2);
    set_scale_all(5'd1);
    start_tile(INT4, 1'b0);
    recv_rows(1'b1, -1, -1);
    idle_check("after_int4");

    // VSQ with findmax set: handled as calc, shift chosen per row
    clear_tile();
    for (int k = 0; k < 16; k++) begin
      set_in(0, k, 1);
      set_exp(0, k, 1);
    end
    set_in(1, 5, 1000);  set_exp(1, 5, 7);
    set_in(1, 6, -1000); set_exp(1, 6, -8);
    exp_scale[1] = 5'd7;
    set_in(2, 0, 20);    set_exp(2, 0, 5);
    exp_scale[2] = 5'd2;
    start_tile(INT4_VSQ, 1'b1);
    recv_rows(1'b1, -1, -1);
    idle_check("after_vsq");

    // Extreme magnitude: -2^23 gives max 2^23-1, s=16
    clear_tile();
    set_in(0, 0, -8388608);
    start_tile(INT8, 1'b1);
    recv_rows(1'b0, -1, -1);
    clear_tile();
    set_in(0, 0, -8388608); set_exp(0, 0, -128);
    set_in(1, 0, 8388607);  set_exp(1, 0, 127);
    set_scale_all(5'd16);
    start_tile(INT8, 1'b0);
    recv_rows(1'b1, -1, -1);
    idle_check("after_extreme");

    // Reset mid calc tile, then max must read as zero
    clear_tile();
    set_in(0, 0, 5000);
    start_tile(INT8, 1'b1);
    recv_rows(1'b0, -1, -1);
    clear_tile();
    for (int r = 0; r < 5; r++) begin
      set_in(r, 0, 5000);
      set_exp(r, 0, 78);
    end
    set_scale_all(5'd6);
    start_tile(INT8, 1'b0);
    recv_rows(1'b1, -1, 5);
    tick();
    clear_tile();
    set_in(0, 0, 100); set_exp(0, 0, 100);
    start_tile(INT8, 1'b0);
    recv_rows(1'b1, -1, -1);
    idle_check("after_reset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ppu_quant.md
# ppu_quant

Post-processing unit that consumes the accumulator row stream from the matrix-multiply controller and requantizes 24-bit partial sums to INT8/INT4. It sits directly downstream of the matmul controller's `o_ppu_start` / `o_acc_data` / `o_mode` / `o_findmax` outputs. For per-tensor modes it runs a first (findmax) pass to derive a shared shift, then quantizes on the calc pass. For `INT4_VSQ` it derives a per-row (per-vector) shift on the fly.

## Interface
- No parameters; modes come from `define.v` macros `INT8`, `INT4`, `INT4_VSQ`.
- `i_clk` in 1 — single clock, rising edge.
- `i_rst_n` in 1 — reset is synchronous and active-low.
- `i_ppu_start` in 1 — one-cycle pulse; the tile's 16 accumulator rows follow on the next 16 cycles.
- `i_acc_data` in 384 — 16 × INT24 (signed), entry k at `[k*24 +: 24]`, one accumulator row per cycle.
- `i_mode` in 2 — quantization mode, sampled with `i_ppu_start`.
- `i_findmax` in 1 — sampled with `i_ppu_start`:
  - 1 = max-search tile, no output.
  - 0 = calc tile.
- `o_valid` out 1 — `o_data`, `o_scale` and `o_row` are valid.
- `o_data` out 128 — 16 × INT8, entry k at `[k*8 +: 8]`; INT4 results sign-extended to 8 bits.
- `o_scale` out 5 — right-shift exponent s applied to this row.
- `o_row` out 4 — row index 0..15 within the tile.
- `o_busy` out 1 — a tile is being received.

## Operation
- **States:** IDLE, RECV.
  - IDLE→RECV on `i_ppu_start`; mode and findmax are latched, and the row counter is cleared.
  - RECV→IDLE after row 15 is received.
  - `i_ppu_start` while in RECV is ignored; the current tile completes unchanged.
- **Max register `max_abs_r` (23 bits, unsigned):**
  - Cleared on reset.
  - Cleared on a findmax start when the previous latched tile was not findmax, i.e. the first tile of a new matrix.
  - In a findmax tile, each received row updates `max_abs_r = max(max_abs_r, |x_k|)` over all 16 entries.
  - `|−2^23|` saturates to `2^23−1`.
  - Frozen during calc tiles.
- **Shift rule:** Q = 8 for `INT8`, Q = 4 for `INT4` and `INT4_VSQ`. Let L = bit length of the magnitude (index of MSB + 1; 0 for zero). Then s = max(0, L − (Q−1)), so s ranges 0..20.
  - Per-tensor modes: L is taken from `max_abs_r`.
  - `INT4_VSQ`: L is taken from the max |x_k| of the current row only. No findmax pass is needed; a findmax tile in VSQ mode is treated as calc.
- **Quantize (calc tiles):**
  - y = (x + (s>0 ? 2^(s−1) : 0)) >>> s, using arithmetic shift and a 25-bit intermediate with no wrap.
  - y is then saturated to [−2^(Q−1), 2^(Q−1)−1].
- **Findmax tiles** never assert `o_valid`.

## Timing
- Define T = the cycle in which `i_ppu_start` is sampled high. Row r is on `i_acc_data` at cycle T+1+r, for r = 0..15.
- `o_busy` is high for cycles T+1..T+16.
- One pipeline register stage: the result for row r is registered and presented at T+2+r, with `o_valid`=1, `o_row`=r and `o_scale`=s.
  - `o_valid` is high for 16 consecutive cycles, T+2..T+17.
- A new `i_ppu_start` at T+16 (last row cycle) is ignored.
  - At T+17 it is accepted: its rows begin at T+18, and `o_valid` of the prior tile ends at T+17 with no gap or overlap.
- Findmax → calc back-to-back: a calc start at T+17 uses `max_abs_r` including row 15 of the findmax tile, which was updated at the T+16 edge.
- **Reset** (synchronous, any cycle, including mid-tile):
  - On the next edge all outputs are 0, state is IDLE, the row counter is 0 and `max_abs_r` is 0.
  - Any partial tile is discarded.

## Test plan
- **Reset:** hold `i_rst_n`=0 for 2 cycles → `o_valid`/`o_busy`/`o_data`/`o_scale`/`o_row` all 0.
- **INT8 per-tensor:**
  - Stimulus: findmax tile with one entry −300 and the rest 0, then a calc tile containing 300 and −300.
  - Required: s=2; outputs 75 and −75; `o_valid` at T+2..T+17 with `o_row` 0..15.
- **INT4 rounding saturation:** findmax max 15, then calc entry 15 → s=1, (15+1)>>1=8 saturates to 7; entry −15 → −7.
- **INT4_VSQ per row:**
  - Row 0 all 1 → s=0, data 1.
  - Row 1 with an entry of 1000 → s=7, (1000+64)>>7=8 saturates to 7, `o_scale`=7.
  - Rows use independent s.
- **Extreme input:** INT8 findmax entry −8388608 (−2^23), then calc of the same value → `max_abs_r`=8388607, s=16, output −128.
- **Protocol corners:**
  - `i_ppu_start` at T+5 → ignored.
  - Back-to-back start at T+17 → 32 contiguous `o_valid` cycles.
  - Reset asserted at row 5 → `o_valid`=0 next cycle, and a subsequent findmax restarts max from 0.
